wb_master_single: RTL
=====================

Name: wb_master_single

Overview:
Single-transfer wishbone initiator. It turns a valid/ready command (address, select, data, write enable) into one wishbone cycle toward a peripheral such as the board I/O block, then returns the read data or a timeout error on a valid/ready response channel. It is the bus-side front end for debug controllers, boot loaders and DMA-less test engines that need programmatic access to the I/O space. Timeout protection keeps an unresponsive slave from hanging the initiator.

Parameters:
ADDR_BITS, 8, address length of the I/O space; bus address carries bits [ADDR_BITS-1:2].
TIMEOUT, 255, cycles to wait for ack before aborting; 0 disables the timeout; maximum 65535.

Ports:
clk  input  1  main clock; bus logic and state all run on it.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when high together with cmd_valid.
cmd_addr  input  ADDR_BITS-2  word address, bits [ADDR_BITS-1:2].
cmd_sel  input  4  byte selects.
cmd_we  input  1  1 = write, 0 = read.
cmd_data  input  32  write data.
resp_valid  output  1  response present.
resp_ready  input  1  response consumed.
resp_data  output  32  read data; 0 for writes and for timeouts.
resp_err  output  1  1 = transfer timed out.
wbm_cs_o  output  1  wishbone cycle/strobe.
wbm_addr_o  output  ADDR_BITS-2  wishbone address [ADDR_BITS-1:2].
wbm_sel_o  output  4  wishbone byte selects.
wbm_data_o  output  32  wishbone write data.
wbm_we_o  output  1  wishbone write enable.
wbm_data_i  input  32  wishbone read data.
wbm_ack_i  input  1  wishbone acknowledge.

Behaviour:
- Reset (asynchronous, active-high): state IDLE. cmd_ready=0 while rst is high, then 1 in IDLE. resp_valid=0, resp_data=0, resp_err=0, wbm_cs_o=0, wbm_addr_o=0, wbm_sel_o=0, wbm_data_o=0, wbm_we_o=0, wait counter=0.
- All outputs are registered except cmd_ready, which is combinational: (state==IDLE) and not rst.
- IDLE:
  - On cmd_valid & cmd_ready at an edge, latch addr/sel/data/we onto the wbm_* outputs, set wbm_cs_o=1, clear the counter, go to BUS.
  - Latency is 1 cycle: cs is visible the cycle after acceptance.
- BUS: wbm_cs_o, address, select, data and we are held stable. At each edge:
  - wbm_ack_i=1: cs<=0; resp_data<=wbm_ack_i-cycle wbm_data_i if read, else 0; resp_err<=0; resp_valid<=1; go to RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: cs<=0, resp_data<=0, resp_err<=1, resp_valid<=1, go to RESP.
  - Else counter++ (16-bit, cannot wrap because TIMEOUT≤65535).
  - Ack and timeout on the same edge: ack wins, and resp_err=0.
  - With a slave that acks one cycle after cs (registered ack), the transfer takes 2 cycles of cs, from acceptance to resp_valid.
- RESP:
  - resp_valid=1 and the response is held stable until resp_ready. On resp_valid & resp_ready: resp_valid<=0, go to IDLE.
  - wbm_* data/addr/sel/we keep their last values; only cs matters.
  - This guarantees at least 2 cycles with cs low between transfers, so a slave that gates on "cs & ~ack" re-arms cleanly.
- A wbm_ack_i seen outside BUS (late ack after a timeout, stray ack) is ignored; it must not alter the response or the state.
- Commands arriving while not in IDLE stall: cmd_ready=0, nothing latched.
- Reset mid-transfer drops wbm_cs_o immediately (asynchronously) and discards any pending response.
- No burst, no retry, no pipelining: exactly one outstanding transfer.

Test Plan:
- Read: model slave (registered ack, addr 0 returns 0x0000_01A5). Command read addr 0, sel 0xF -> cs high for exactly 2 cycles; resp_data=0x0000_01A5, resp_err=0; resp_valid 1 cycle after ack.
- Write then readback: write addr 6, sel 0xF, data 0x1234_F0FF; then write addr 6, sel 0x1, data 0x0000_00AA; then read addr 6 -> resp_data=0x1234_F0AA. On writes, resp_data=0.
- Timeout: TIMEOUT=4, slave never acks -> cs high exactly 4 cycles then low; resp_err=1, resp_data=0. A late ack injected 2 cycles after that causes no change.
- Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid and resp_data stay stable, cmd_ready=0, and a pending cmd_valid is not accepted until 1 cycle after the resp handshake.
- Ack on the timeout edge: TIMEOUT=3, slave acks on the 3rd cs cycle -> resp_err=0, data captured.
- Async reset mid-BUS: assert rst between edges during a cycle with cs high -> wbm_cs_o=0 and resp_valid=0 before the next edge; after release, a fresh read completes normally.

Source files
------------

// File: rtl/wb_master_single.sv
// Single-transfer wishbone initiator: one valid/ready command becomes one bus cycle,
// answered on a valid/ready response channel with read data or a timeout error.
module wb_master_single #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-3:0] cmd_addr,
  input  logic [3:0]           cmd_sel,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic                 wbm_cs_o,
  output logic [ADDR_BITS-3:0] wbm_addr_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_data_o,
  output logic                 wbm_we_o,
  input  logic [31:0]          wbm_data_i,
  input  logic                 wbm_ack_i
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] wait_cnt_q;

  assign cmd_ready = (state_q == StIdle) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      wbm_cs_o   <= 1'b0;
      wbm_addr_o <= '0;
      wbm_sel_o  <= '0;
      wbm_data_o <= '0;
      wbm_we_o   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            wbm_addr_o <= cmd_addr;
            wbm_sel_o  <= cmd_sel;
            wbm_data_o <= cmd_data;
            wbm_we_o   <= cmd_we;
            wbm_cs_o   <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= StBus;
          end
        end
        StBus: begin
          // Ack is checked first so an ack on the timeout edge still completes cleanly.
          if (wbm_ack_i) begin
            wbm_cs_o   <= 1'b0;
            resp_data  <= wbm_we_o ? 32'h0 : wbm_data_i;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else if (TimeoutEn && (wait_cnt_q == TimeoutLast)) begin
            wbm_cs_o   <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
